mc_main_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 42 ++++
 rtl/alu_decoder.sv | 63 ++++++
 rtl/mc_main_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs, ALU ops, FSM states, mux selects.
// Pure declarations; no logic, no latency.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
        OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
        OP_LW    = 6'h23, OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04,
        F_SRLV = 6'h06, F_SRAV = 6'h07, F_ADD  = 6'h20, F_ADDU = 6'h21,
        F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
        F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_XOR  = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11
    } alu_ctrl_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
        S_MEM_WB   = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC   = 4'd6, S_ALU_WB = 4'd7,
        S_I_EXEC   = 4'd8, S_I_WB   = 4'd9, S_BRANCH   = 4'd10, S_JUMP  = 4'd11
    } ctrl_state_t;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS     = 2'b01;
    localparam logic [1:0] SRC_A_SHAMT  = 2'b10;
    localparam logic [1:0] SRC_B_RT     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_BR_OFS = 2'b11;
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decode: ALU operation, shift-by-shamt flag, zero-extend flag, legality.
// Zero latency; no flow control.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       in_r_exec,
    output alu_ctrl_t  alu_ctrl,
    output logic       shift_imm,
    output logic       imm_zext,
    output logic       legal
);

    alu_ctrl_t r_op;
    alu_ctrl_t i_op;
    logic      r_legal;

    always_comb begin
        r_op      = ALU_ADD;
        r_legal   = 1'b1;
        shift_imm = 1'b0;
        case (funct)
            F_ADD, F_ADDU: r_op = ALU_ADD;
            F_SUB, F_SUBU: r_op = ALU_SUB;
            F_AND:         r_op = ALU_AND;
            F_OR:          r_op = ALU_OR;
            F_XOR:         r_op = ALU_XOR;
            F_NOR:         r_op = ALU_NOR;
            F_SLT:         r_op = ALU_SLT;
            F_SLTU:        r_op = ALU_SLTU;
            F_SLL:         begin r_op = ALU_SLL; shift_imm = 1'b1; end
            F_SRL:         begin r_op = ALU_SRL; shift_imm = 1'b1; end
            F_SRA:         begin r_op = ALU_SRA; shift_imm = 1'b1; end
            F_SLLV:        r_op = ALU_SLL;
            F_SRLV:        r_op = ALU_SRL;
            F_SRAV:        r_op = ALU_SRA;
            default:       r_legal = 1'b0;
        endcase
    end

    always_comb begin
        i_op     = ALU_ADD;
        imm_zext = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OP_RTYPE:                    legal = r_legal;
            OP_J, OP_BEQ, OP_BNE,
            OP_LW, OP_SW,
            OP_ADDI, OP_ADDIU:           i_op = ALU_ADD;
            OP_SLTI:                     i_op = ALU_SLT;
            OP_SLTIU:                    i_op = ALU_SLTU;
            OP_ANDI:                     begin i_op = ALU_AND; imm_zext = 1'b1; end
            OP_ORI:                      begin i_op = ALU_OR;  imm_zext = 1'b1; end
            OP_XORI:                     begin i_op = ALU_XOR; imm_zext = 1'b1; end
            OP_LUI:                      i_op = ALU_LUI;
            default:                     legal = 1'b0;
        endcase
    end

    assign alu_ctrl = in_r_exec ? r_op : i_op;

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: lw 5, sw 4, R/I 4, branch/jump 3 cycles, plus one per memory stall.
// Memory states hold their request until mem_ready; mem_timeout flags a long stall without aborting.
module mc_main_ctrl
    import mips_pkg::*;
#(
    parameter ctrl_state_t RESET_STATE = S_FETCH,
    parameter int unsigned WAIT_LIMIT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [1:0] pc_src,
    output logic [3:0] alu_ctrl,
    output logic       illegal_instr,
    output logic       mem_timeout,
    output logic [3:0] state_debug
);

    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    alu_ctrl_t     dec_alu_ctrl;
    logic          dec_shift_imm, dec_imm_zext, dec_legal;
    logic          in_r_exec, mem_wait;

    assign in_r_exec = (state_q == S_R_EXEC);
    assign mem_wait  = (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !mem_ready;

    alu_decoder u_alu_decoder (
        .opcode    (opcode),
        .funct     (funct),
        .in_r_exec (in_r_exec),
        .alu_ctrl  (dec_alu_ctrl),
        .shift_imm (dec_shift_imm),
        .imm_zext  (dec_imm_zext),
        .legal     (dec_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        pc_en         = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RT;
        imm_zext      = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_ctrl      = ALU_ADD;
        illegal_instr = 1'b0;
        mem_timeout   = 1'b0;
        state_debug   = state_q;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                pc_en     = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target lands in ALUOut for S_BRANCH
                alu_src_b = SRC_B_BR_OFS;
                if (!dec_legal) begin
                    illegal_instr = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                        OP_RTYPE:      state_d = S_R_EXEC;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:          state_d = S_JUMP;
                        default:       state_d = S_I_EXEC;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = dec_shift_imm ? SRC_A_SHAMT : SRC_A_RS;
                alu_ctrl  = dec_alu_ctrl;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_IMM;
                imm_zext  = dec_imm_zext;
                alu_ctrl  = dec_alu_ctrl;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS;
                alu_ctrl  = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_en     = (opcode == OP_BNE) ? !alu_zero : alu_zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = PC_SRC_JUMP;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (WAIT_LIMIT != 0 && mem_wait) begin
            if (wait_cnt_q != LIMIT) begin
                wait_cnt_d  = wait_cnt_q + CW'(1);
                mem_timeout = (wait_cnt_d == LIMIT);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end

        // Strobes must vanish the instant reset rises, not at the next edge
        if (reset) begin
            pc_en         = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_a     = SRC_A_PC;
            alu_src_b     = SRC_B_RT;
            imm_zext      = 1'b0;
            pc_src        = PC_SRC_ALU;
            alu_ctrl      = ALU_ADD;
            illegal_instr = 1'b0;
            mem_timeout   = 1'b0;
            state_debug   = S_FETCH;
        end
    end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Randomized instruction stream against an instruction-level model of the control sequence.
module tb_mc_main_ctrl;
    import mips_pkg::*;

    localparam int WL = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0] alu_src_a, alu_src_b, pc_src;
    logic       imm_zext, illegal_instr, mem_timeout;
    logic [3:0] alu_ctrl, state_debug;
    logic [24:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_main_ctrl #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext), .pc_src(pc_src),
        .alu_ctrl(alu_ctrl), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout),
        .state_debug(state_debug)
    );

    assign obs = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, imm_zext, pc_src, alu_ctrl, illegal_instr, mem_timeout,
                  state_debug};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00)
            return fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B};
        return op inside {6'h02, 6'h04, 6'h05, [6'h08:6'h0F], 6'h23, 6'h2B};
    endfunction

    function automatic logic [3:0] alu_of_funct(input logic [5:0] fn);
        case (fn)
            6'h22, 6'h23: return ALU_SUB;
            6'h24:        return ALU_AND;
            6'h25:        return ALU_OR;
            6'h26:        return ALU_XOR;
            6'h27:        return ALU_NOR;
            6'h2A:        return ALU_SLT;
            6'h2B:        return ALU_SLTU;
            6'h00, 6'h04: return ALU_SLL;
            6'h02, 6'h06: return ALU_SRL;
            6'h03, 6'h07: return ALU_SRA;
            default:      return ALU_ADD;
        endcase
    endfunction

    function automatic logic [3:0] alu_of_op(input logic [5:0] op);
        case (op)
            6'h0A:   return ALU_SLT;
            6'h0B:   return ALU_SLTU;
            6'h0C:   return ALU_AND;
            6'h0D:   return ALU_OR;
            6'h0E:   return ALU_XOR;
            6'h0F:   return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

    // Expected control word for one cycle of a given instruction step
    function automatic logic [24:0] expect_word(input ctrl_state_t s, input logic [5:0] op,
            input logic [5:0] fn, input logic rdy, input logic z, input logic tmo);
        logic pe = 0, iod = 0, mr = 0, mw = 0, irw = 0, rw = 0, rd = 0, m2r = 0, zx = 0, ill = 0;
        logic [1:0] sa = 0, sb = 0, ps = 0;
        logic [3:0] alu = ALU_ADD;
        case (s)
            S_FETCH:    begin mr = 1; sb = 2'b01; pe = rdy; irw = rdy; end
            S_DECODE:   begin sb = 2'b11; ill = !is_legal(op, fn); end
            S_MEM_ADDR: begin sa = 2'b01; sb = 2'b10; end
            S_MEM_RD:   begin mr = 1; iod = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin mw = 1; iod = 1; end
            S_R_EXEC:   begin sa = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
                              alu = alu_of_funct(fn); end
            S_ALU_WB:   begin rw = 1; rd = 1; end
            S_I_EXEC:   begin sa = 2'b01; sb = 2'b10; zx = op inside {6'h0C, 6'h0D, 6'h0E};
                              alu = alu_of_op(op); end
            S_I_WB:     rw = 1;
            S_BRANCH:   begin sa = 2'b01; alu = ALU_SUB; ps = 2'b01;
                              pe = (op == 6'h05) ? !z : z; end
            S_JUMP:     begin ps = 2'b10; pe = 1; end
            default:    ;
        endcase
        return {pe, iod, mr, mw, irw, rw, rd, m2r, sa, sb, zx, ps, alu, ill, tmo, 4'(s)};
    endfunction

    // Drive one whole instruction; st_f/st_m are stall cycles in fetch/data-memory states,
    // zmode 0/1 forces alu_zero, 2 randomizes it per cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int st_f, input int st_m, input int zmode);
        ctrl_state_t seq[$];
        seq = '{S_FETCH, S_DECODE};
        if (is_legal(op, fn)) begin
            case (op)
                6'h23:        begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_RD); seq.push_back(S_MEM_WB); end
                6'h2B:        begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_WR); end
                6'h00:        begin seq.push_back(S_R_EXEC); seq.push_back(S_ALU_WB); end
                6'h04, 6'h05: seq.push_back(S_BRANCH);
                6'h02:        seq.push_back(S_JUMP);
                default:      begin seq.push_back(S_I_EXEC); seq.push_back(S_I_WB); end
            endcase
        end
        foreach (seq[k]) begin
            ctrl_state_t s = seq[k];
            logic is_mem = s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
            int stalls = (s == S_FETCH) ? st_f : (is_mem ? st_m : 0);
            for (int c = 0; c <= stalls; c++) begin
                logic rdy = is_mem ? (c == stalls) : 1'($urandom_range(0, 1));
                logic z   = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
                opcode = op; funct = fn; mem_ready = rdy; alu_zero = z;
                @(negedge clk);
                chk_eq(s.name(), 32'(obs),
                       32'(expect_word(s, op, fn, rdy, z, is_mem && !rdy && (c + 1 == WL))));
                @(posedge clk);
                #1;
            end
        end
    endtask

    logic [5:0] op_pool [19] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h10};
    logic [5:0] fn_pool [19] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                                 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h08, 6'h3F};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; opcode = 6'h23; funct = 6'h20; alu_zero = 1'b1; mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_eq("reset_outputs", 32'(obs), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(6'h00, 6'h20, 0, 0, 2);   // add
        run_instr(6'h23, 6'h00, 0, 3, 2);   // lw with 3 stalls in S_MEM_RD
        run_instr(6'h04, 6'h00, 0, 0, 1);   // beq taken
        run_instr(6'h04, 6'h00, 0, 0, 0);   // beq not taken
        run_instr(6'h05, 6'h00, 0, 0, 1);   // bne
        run_instr(6'h05, 6'h00, 0, 0, 0);
        run_instr(6'h00, 6'h00, 0, 0, 2);   // sll
        run_instr(6'h00, 6'h04, 0, 0, 2);   // sllv
        run_instr(6'h00, 6'h2B, 0, 0, 2);   // sltu
        run_instr(6'h3F, 6'h00, 0, 0, 2);   // illegal opcode
        run_instr(6'h00, 6'h3F, 0, 0, 2);   // illegal funct
        run_instr(6'h2B, 6'h00, 3, 2, 2);   // sw with fetch and write stalls

        // Async reset while a store is waiting on memory
        opcode = 6'h2B; funct = 6'h00; alu_zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        chk_eq("sw_wr_before_reset", 32'(mem_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_eq("async_mem_write", 32'(mem_write), 32'd0);
        chk_eq("async_state", 32'(state_debug), 32'(S_FETCH));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_eq("reset_hold", 32'(obs), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 80; i++) begin
            run_instr(op_pool[$urandom_range(0, 18)], fn_pool[$urandom_range(0, 18)],
                      $urandom_range(0, 3), $urandom_range(0, 3), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
